ball_paddle: RTL and testbench
==============================

Name: ball_paddle

Overview:
- Consumes the paddle's BarX/BarY/Bar_Sizex/Bar_Sizey and the shared keycode; owns ball position, serve/play/life-loss sequencing and the paddle reset request.
- Outputs ball centre and size to the colour mapper and the brick block.
- Drives Bar_Reset back into the paddle.
- Updates once per frame_clk rising edge.

Parameters:
- BALL_SIZE, 4: ball half-width in pixels.
- BALL_STEP, 2: per-frame speed magnitude on each axis.
- X_MIN, 0: left wall.
- X_MAX, 639: right wall.
- Y_MIN, 0: ceiling.
- Y_MAX, 479: floor (life-loss line).
- LIVES_INIT, 3: lives at reset and restart.
- LOST_FRAMES, 60: frames spent in LOST.
- KEY_LAUNCH, 8'h2C: launch/restart keycode (space).

Ports:
- frame_clk  in  1  frame-rate clock; all state changes on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- keycode  in  8  current keyboard keycode; 0 = none.
- BarX  in  10  paddle centre X.
- BarY  in  10  paddle centre Y.
- Bar_Sizex  in  10  paddle half-width.
- Bar_Sizey  in  10  paddle half-height.
- Brick_Hit  in  1  brick block reports a collision for the current ball position.
- Brick_Hit_Side  in  1  0 = top/bottom face (flip Y), 1 = left/right face (flip X).
- BallX  out  10  ball centre X.
- BallY  out  10  ball centre Y.
- Ball_Size  out  10  constant BALL_SIZE.
- Bar_Reset  out  1  paddle recentre request.
- Lives  out  2  remaining lives.
- Game_Over  out  1  high in OVER.
- Ball_Launched  out  1  high in PLAY.

Behaviour:
- One clock (frame_clk); reset is asynchronous and active-low (Reset_n).
- Reset values:
  - state = SERVE, Lives = LIVES_INIT, motion X/Y = 0, frame counter = 0.
  - BallX = 320, BallY = 452.
  - Bar_Reset = 0, Game_Over = 0, Ball_Launched = 0.
- Arithmetic:
  - Motion registers are 10-bit two's complement; position update is 10-bit modular.
  - All edge compares use the same 10-bit unsigned sums, computed as the literal expressions given.
- SERVE:
  - BallX <= BarX; BallY <= BarY - Bar_Sizey - BALL_SIZE - 1; motion held at 0.
  - keycode == KEY_LAUNCH: motion X = +STEP, Y = -STEP, go to PLAY. Position uses the new motion in the same edge, so the first PLAY frame shows (BarX+2, SERVE_Y-2).
- PLAY: each edge computes next motion, then pos <= pos + next motion, evaluated in priority order:
  1. Floor: BallY + BALL_SIZE >= Y_MAX.
     - Lives decrements.
     - If the new value is 0: OVER. Otherwise: LOST, frame counter cleared.
     - Position frozen this edge.
  2. Paddle hit: all four conditions must hold.
     - Y motion positive.
     - BallY + BALL_SIZE >= BarY - Bar_Sizey.
     - BallY <= BarY.
     - BallX + BALL_SIZE >= BarX - Bar_Sizex and BallX <= BarX + Bar_Sizex + BALL_SIZE.
     - Response: Y motion = -STEP. X motion = -STEP if BallX < BarX - Bar_Sizex/2, +STEP if BallX > BarX + Bar_Sizex/2, else unchanged.
  3. Brick_Hit:
     - Side 0 negates Y motion; side 1 negates X motion.
     - Ignored on the same edge as a paddle hit.
  4. Walls:
     - BallX - BALL_SIZE <= X_MIN and X motion negative: X = +STEP.
     - BallX + BALL_SIZE >= X_MAX and X motion positive: X = -STEP.
     - BallY - BALL_SIZE <= Y_MIN and Y motion negative: Y = +STEP.
     - Wall X handling applies after a Y-only brick flip. A wall that contradicts a brick X flip wins.
  - Corner case: wall X and ceiling Y both apply on the same edge.
- LOST:
  - Bar_Reset = 1 every frame; ball frozen; motion = 0.
  - Counter increments each frame. When counter == LOST_FRAMES-1: go to SERVE, Bar_Reset drops on that edge.
- OVER:
  - Game_Over = 1, ball frozen, Lives = 0, keycode ignored except KEY_LAUNCH.
  - On KEY_LAUNCH: Lives = LIVES_INIT, Bar_Reset = 1 for exactly one frame, then SERVE.
- Outputs:
  - Bar_Reset, Game_Over and Ball_Launched are registered and follow the state on the same edge as the transition.
  - Lives never underflows.
- Reset asserted mid-PLAY, mid-LOST or in OVER: immediately returns to the reset values; no Bar_Reset pulse is produced.
- Keycodes other than KEY_LAUNCH have no effect on this block.

Test Plan:
1. Reset with BarX=320, BarY=460, Sizex=20, Sizey=3 → (320,452), Lives=3, SERVE. Move BarX to 340 → BallX=340 next frame.
2. Serve at (320,452), keycode 8'h2C for one frame → (322,450), Ball_Launched=1. Next frame (324,448).
3. Ball at (636,200) moving (+2,-2) → X motion -2, next (634,198). Ball at (100,4) moving (-2,-2) → next (98,6).
4. Ball at (300,453) moving (+2,+2), BarX=320 → X=-2, Y=-2, next (298,451). BallX=320 → X unchanged (+2), next (322,451).
5. Brick_Hit=1, side 0, with ball (200,100) moving (+2,-2) → next (202,102). Brick_Hit together with a paddle hit → only the paddle response applies.
6. Ball reaches Y=475 with Lives=1 → Lives=0, Game_Over=1, ball frozen. KEY_LAUNCH → Lives=3, Bar_Reset high exactly one frame, SERVE. Separately, Lives=2 loss → Bar_Reset high 60 frames, then SERVE.

Source files
------------

// File: rtl/ball_paddle.sv
// rtl/ball_paddle.sv - ball motion, serve/play/life-loss sequencing and paddle recentre request
module ball_paddle #(
    parameter int         BALL_SIZE   = 4,
    parameter int         BALL_STEP   = 2,
    parameter int         X_MIN       = 0,
    parameter int         X_MAX       = 639,
    parameter int         Y_MIN       = 0,
    parameter int         Y_MAX       = 479,
    parameter int         LIVES_INIT  = 3,
    parameter int         LOST_FRAMES = 60,
    parameter logic [7:0] KEY_LAUNCH  = 8'h2C
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic [7:0] keycode,
    input  logic [9:0] BarX,
    input  logic [9:0] BarY,
    input  logic [9:0] Bar_Sizex,
    input  logic [9:0] Bar_Sizey,
    input  logic       Brick_Hit,
    input  logic       Brick_Hit_Side,
    output logic [9:0] BallX,
    output logic [9:0] BallY,
    output logic [9:0] Ball_Size,
    output logic       Bar_Reset,
    output logic [1:0] Lives,
    output logic       Game_Over,
    output logic       Ball_Launched
);

    localparam logic [9:0] BS     = 10'(BALL_SIZE);
    localparam logic [9:0] STEP   = 10'(BALL_STEP);
    localparam logic [9:0] NSTEP  = 10'(-BALL_STEP);
    localparam logic [9:0] XMIN   = 10'(X_MIN);
    localparam logic [9:0] XMAX   = 10'(X_MAX);
    localparam logic [9:0] YMIN   = 10'(Y_MIN);
    localparam logic [9:0] YMAX   = 10'(Y_MAX);
    localparam logic [1:0] LIVES0 = 2'(LIVES_INIT);
    localparam int         CW     = $clog2(LOST_FRAMES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LOST_FRAMES - 1);

    typedef enum logic [1:0] {
        S_SERVE,
        S_PLAY,
        S_LOST,
        S_OVER
    } state_t;

    state_t        state, state_nx;
    logic [9:0]    mot_x, mot_y, mot_x_nx, mot_y_nx;
    logic [9:0]    ball_x_nx, ball_y_nx;
    logic [9:0]    mx, my;
    logic [1:0]    lives_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          bar_reset_nx;

    // All edge tests use 10-bit wrapped sums so the compares match the modular position math.
    logic [9:0] serve_y, y_bot, y_top, x_rt, x_lf;
    logic [9:0] bar_top, bar_lf, bar_rt, zone_lf, zone_rt;
    logic       mot_y_pos, paddle_hit, floor_hit, launch;

    assign serve_y    = BarY - Bar_Sizey - BS - 10'd1;
    assign y_bot      = BallY + BS;
    assign y_top      = BallY - BS;
    assign x_rt       = BallX + BS;
    assign x_lf       = BallX - BS;
    assign bar_top    = BarY - Bar_Sizey;
    assign bar_lf     = BarX - Bar_Sizex;
    assign bar_rt     = BarX + Bar_Sizex + BS;
    assign zone_lf    = BarX - {1'b0, Bar_Sizex[9:1]};
    assign zone_rt    = BarX + {1'b0, Bar_Sizex[9:1]};
    assign mot_y_pos  = !mot_y[9] && (mot_y != 10'd0);
    assign paddle_hit = mot_y_pos && (y_bot >= bar_top) && (BallY <= BarY)
                        && (x_rt >= bar_lf) && (BallX <= bar_rt);
    assign floor_hit  = y_bot >= YMAX;
    assign launch     = keycode == KEY_LAUNCH;
    assign Ball_Size  = BS;

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state         <= S_SERVE;
            BallX         <= 10'd320;
            BallY         <= 10'd452;
            mot_x         <= 10'd0;
            mot_y         <= 10'd0;
            Lives         <= LIVES0;
            cnt           <= '0;
            Bar_Reset     <= 1'b0;
            Game_Over     <= 1'b0;
            Ball_Launched <= 1'b0;
        end else begin
            state         <= state_nx;
            BallX         <= ball_x_nx;
            BallY         <= ball_y_nx;
            mot_x         <= mot_x_nx;
            mot_y         <= mot_y_nx;
            Lives         <= lives_nx;
            cnt           <= cnt_nx;
            Bar_Reset     <= bar_reset_nx;
            Game_Over     <= (state_nx == S_OVER);
            Ball_Launched <= (state_nx == S_PLAY);
        end
    end

    always_comb begin
        state_nx     = state;
        ball_x_nx    = BallX;
        ball_y_nx    = BallY;
        mot_x_nx     = mot_x;
        mot_y_nx     = mot_y;
        lives_nx     = Lives;
        cnt_nx       = cnt;
        bar_reset_nx = 1'b0;
        mx           = mot_x;
        my           = mot_y;

        case (state)
            S_SERVE: begin
                mot_x_nx  = 10'd0;
                mot_y_nx  = 10'd0;
                ball_x_nx = BarX;
                ball_y_nx = serve_y;
                if (launch) begin
                    mot_x_nx  = STEP;
                    mot_y_nx  = NSTEP;
                    ball_x_nx = BarX + STEP;
                    ball_y_nx = serve_y + NSTEP;
                    state_nx  = S_PLAY;
                end
            end

            S_PLAY: begin
                if (floor_hit) begin
                    mot_x_nx = 10'd0;
                    mot_y_nx = 10'd0;
                    if (Lives <= 2'd1) begin
                        lives_nx = 2'd0;
                        state_nx = S_OVER;
                    end else begin
                        lives_nx     = Lives - 2'd1;
                        cnt_nx       = '0;
                        bar_reset_nx = 1'b1;
                        state_nx     = S_LOST;
                    end
                end else begin
                    if (paddle_hit) begin
                        my = NSTEP;
                        if (BallX < zone_lf)
                            mx = NSTEP;
                        else if (BallX > zone_rt)
                            mx = STEP;
                    end else if (Brick_Hit) begin
                        if (Brick_Hit_Side)
                            mx = 10'd0 - mot_x;
                        else
                            my = 10'd0 - mot_y;
                    end
                    // Walls see the post-brick motion, so a wall overrides a contradicting X flip.
                    if ((x_lf <= XMIN) && mx[9])
                        mx = STEP;
                    if ((x_rt >= XMAX) && !mx[9] && (mx != 10'd0))
                        mx = NSTEP;
                    if ((y_top <= YMIN) && my[9])
                        my = STEP;
                    mot_x_nx  = mx;
                    mot_y_nx  = my;
                    ball_x_nx = BallX + mx;
                    ball_y_nx = BallY + my;
                end
            end

            S_LOST: begin
                mot_x_nx     = 10'd0;
                mot_y_nx     = 10'd0;
                bar_reset_nx = 1'b1;
                cnt_nx       = cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    bar_reset_nx = 1'b0;
                    cnt_nx       = '0;
                    state_nx     = S_SERVE;
                end
            end

            S_OVER: begin
                mot_x_nx = 10'd0;
                mot_y_nx = 10'd0;
                lives_nx = 2'd0;
                if (launch) begin
                    lives_nx     = LIVES0;
                    bar_reset_nx = 1'b1;
                    state_nx     = S_SERVE;
                end
            end

            default: state_nx = S_SERVE;
        endcase
    end

endmodule

// File: tb/tb_ball_paddle.sv
// tb/tb_ball_paddle.sv - self-checking bench for ball_paddle
module tb_ball_paddle;

    logic       frame_clk = 1'b0;
    logic       Reset_n;
    logic [7:0] keycode;
    logic [9:0] BarX, BarY, Bar_Sizex, Bar_Sizey;
    logic       Brick_Hit, Brick_Hit_Side;
    logic [9:0] BallX, BallY, Ball_Size;
    logic       Bar_Reset;
    logic [1:0] Lives;
    logic       Game_Over, Ball_Launched;

    int n_tests = 0;
    int n_fail  = 0;

    ball_paddle dut (
        .frame_clk     (frame_clk),
        .Reset_n       (Reset_n),
        .keycode       (keycode),
        .BarX          (BarX),
        .BarY          (BarY),
        .Bar_Sizex     (Bar_Sizex),
        .Bar_Sizey     (Bar_Sizey),
        .Brick_Hit     (Brick_Hit),
        .Brick_Hit_Side(Brick_Hit_Side),
        .BallX         (BallX),
        .BallY         (BallY),
        .Ball_Size     (Ball_Size),
        .Bar_Reset     (Bar_Reset),
        .Lives         (Lives),
        .Game_Over     (Game_Over),
        .Ball_Launched (Ball_Launched)
    );

    always #5 frame_clk = ~frame_clk;

    localparam int MS_SERVE = 10, MS_PLAY = 11, MS_LOST = 12, MS_OVER = 13;

    typedef struct {
        int mode;
        int x;
        int y;
        int vx;
        int vy;
        int lives;
        int cnt;
        int br;
    } mdl_t;

    mdl_t m;

    function automatic int u10(input int v);
        return v & 1023;
    endfunction

    function automatic mdl_t mdl_rst();
        mdl_t r;
        r.mode = MS_SERVE; r.x = 320; r.y = 452; r.vx = 0; r.vy = 0;
        r.lives = 3; r.cnt = 0; r.br = 0;
        return r;
    endfunction

    // Game rules applied with plain integers; velocities are signed ints, positions wrap at 1024.
    function automatic mdl_t mdl_step(input mdl_t c, input int kc, input int bx, input int by,
                                      input int sx, input int sy, input int bh, input int bs);
        mdl_t n;
        int   vx, vy;
        bit   pad;
        n = c;
        n.br = 0;
        vx = c.vx;
        vy = c.vy;
        if (c.mode == MS_SERVE) begin
            n.x = bx; n.y = u10(by - sy - 5); n.vx = 0; n.vy = 0;
            if (kc == 44) begin
                n.vx = 2; n.vy = -2;
                n.x = u10(bx + 2); n.y = u10(by - sy - 5 - 2);
                n.mode = MS_PLAY;
            end
        end else if (c.mode == MS_PLAY) begin
            if (u10(c.y + 4) >= 479) begin
                n.lives = c.lives - 1; n.vx = 0; n.vy = 0;
                if (n.lives == 0) n.mode = MS_OVER;
                else begin n.mode = MS_LOST; n.cnt = 0; n.br = 1; end
            end else begin
                pad = (c.vy > 0) && (u10(c.y + 4) >= u10(by - sy)) && (c.y <= by)
                      && (u10(c.x + 4) >= u10(bx - sx)) && (c.x <= u10(bx + sx + 4));
                if (pad) begin
                    vy = -2;
                    if (c.x < u10(bx - sx / 2)) vx = -2;
                    else if (c.x > u10(bx + sx / 2)) vx = 2;
                end else if (bh != 0) begin
                    if (bs != 0) vx = -vx; else vy = -vy;
                end
                if (u10(c.x - 4) <= 0 && vx < 0) vx = 2;
                if (u10(c.x + 4) >= 639 && vx > 0) vx = -2;
                if (u10(c.y - 4) <= 0 && vy < 0) vy = 2;
                n.vx = vx; n.vy = vy;
                n.x = u10(c.x + vx); n.y = u10(c.y + vy);
            end
        end else if (c.mode == MS_LOST) begin
            n.vx = 0; n.vy = 0;
            if (c.cnt == 59) n.mode = MS_SERVE;
            else begin n.cnt = c.cnt + 1; n.br = 1; end
        end else begin
            if (kc == 44) begin n.lives = 3; n.mode = MS_SERVE; n.br = 1; end
        end
        return n;
    endfunction

    always @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) m <= mdl_rst();
        else m <= mdl_step(m, keycode, BarX, BarY, Bar_Sizex, Bar_Sizey, Brick_Hit, Brick_Hit_Side);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge frame_clk) begin
        chk("model_BallX", BallX, m.x);
        chk("model_BallY", BallY, m.y);
        chk("model_Lives", Lives, m.lives);
        chk("model_Bar_Reset", Bar_Reset, m.br);
        chk("model_Game_Over", Game_Over, int'(m.mode == MS_OVER));
        chk("model_Ball_Launched", Ball_Launched, int'(m.mode == MS_PLAY));
        chk("model_Ball_Size", Ball_Size, 4);
    end

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        #1;
        Reset_n = 1'b1;
    endtask

    task automatic pos(input string nm, input int ex, input int ey);
        chk({nm, "_x"}, BallX, ex);
        chk({nm, "_y"}, BallY, ey);
    endtask

    task automatic wait_x(input int tx, input int maxf, input string nm);
        int k = 0;
        while (BallX != tx && k < maxf) begin tick(); k++; end
        chk(nm, BallX, tx);
    endtask

    task automatic wait_y(input int ty, input int maxf, input string nm);
        int k = 0;
        while (BallY != ty && k < maxf) begin tick(); k++; end
        chk(nm, BallY, ty);
    endtask

    task automatic wait_drop(input int maxf, input string nm);
        int k = 0;
        while (Ball_Launched && k < maxf) begin tick(); k++; end
        chk(nm, Ball_Launched, 0);
    endtask

    task automatic count_lost();
        int c = 0;
        while (Bar_Reset && c < 100) begin c++; tick(); end
        chk("lost_frames", c, 60);
        chk("lost_exit_launched", Ball_Launched, 0);
    endtask

    // Serve at (100,453), flip downward with a brick, paddle moved away; ball freezes at (126,475).
    task automatic lose_life(input int exp_lives);
        BarX = 100; BarY = 461; Bar_Sizey = 3; Brick_Hit = 0; keycode = 8'h00;
        tick();
        pos("ll_serve", 100, 453);
        keycode = 8'h2C;
        tick();
        keycode = 8'h00; BarX = 600; Brick_Hit = 1; Brick_Hit_Side = 0;
        tick();
        Brick_Hit = 0;
        pos("ll_flip", 104, 453);
        wait_drop(40, "ll_floor_timeout");
        pos("ll_frozen", 126, 475);
        chk("ll_lives", Lives, exp_lives);
        chk("ll_bar_reset", Bar_Reset, int'(exp_lives != 0));
        chk("ll_game_over", Game_Over, int'(exp_lives == 0));
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        Reset_n = 1'b0; keycode = 8'h00;
        BarX = 320; BarY = 460; Bar_Sizex = 20; Bar_Sizey = 3;
        Brick_Hit = 0; Brick_Hit_Side = 0;
        tick(); tick();
        pos("reset", 320, 452);
        chk("reset_lives", Lives, 3);
        chk("reset_game_over", Game_Over, 0);
        chk("reset_launched", Ball_Launched, 0);
        chk("reset_bar_reset", Bar_Reset, 0);
        chk("reset_ball_size", Ball_Size, 4);
        Reset_n = 1'b1;

        BarX = 340; tick();
        pos("serve_track", 340, 452);
        BarX = 320; tick();
        keycode = 8'h2C; tick();
        pos("launch", 322, 450);
        chk("launch_launched", Ball_Launched, 1);
        chk("pin_model_x", m.x, 322);
        chk("pin_model_vy", m.vy, -2);
        keycode = 8'h1A; tick();
        pos("launch_next", 324, 448);
        keycode = 8'h00;

        // Right wall, ceiling, left wall, then the floor.
        do_reset();
        BarX = 400; BarY = 444; Bar_Sizey = 3; tick();
        pos("s3_serve", 400, 436);
        keycode = 8'h2C; tick(); keycode = 8'h00;
        pos("s3_launch", 402, 434);
        wait_x(636, 200, "right_wall_reach");
        chk("right_wall_y", BallY, 200);
        tick();
        pos("right_wall_bounce", 634, 198);
        wait_y(4, 150, "ceiling_reach");
        chk("ceiling_x", BallX, 440);
        tick();
        pos("ceiling_bounce", 438, 6);
        wait_x(4, 300, "left_wall_reach");
        chk("left_wall_y", BallY, 440);
        tick();
        pos("left_wall_bounce", 6, 442);
        wait_drop(40, "s3_floor_timeout");
        pos("s3_floor", 40, 476);
        chk("s3_lives", Lives, 2);
        chk("s3_bar_reset", Bar_Reset, 1);
        count_lost();
        chk("pin_model_lives", m.lives, 2);
        tick();
        pos("s3_reserve", 400, 436);

        // Paddle left zone, then centre zone with a simultaneous side brick.
        do_reset();
        BarX = 296; BarY = 461; Bar_Sizey = 3; tick();
        pos("s4_serve", 296, 453);
        keycode = 8'h2C; tick(); keycode = 8'h00;
        Brick_Hit = 1; Brick_Hit_Side = 0; tick();
        pos("s4_flip", 300, 453);
        Brick_Hit = 0; BarX = 320; BarY = 460; tick();
        pos("paddle_left", 298, 451);
        tick();
        pos("paddle_left_next", 296, 449);
        do_reset();
        BarX = 316; BarY = 461; tick();
        keycode = 8'h2C; tick(); keycode = 8'h00;
        Brick_Hit = 1; Brick_Hit_Side = 0; tick();
        pos("s4b_flip", 320, 453);
        BarX = 320; BarY = 460; Brick_Hit = 1; Brick_Hit_Side = 1; tick();
        pos("paddle_centre_brick", 322, 451);
        Brick_Hit = 0; tick();
        pos("paddle_centre_next", 324, 449);

        // Brick faces in open field.
        do_reset();
        BarX = 108; BarY = 200; Bar_Sizey = 3; tick();
        pos("s5_serve", 108, 192);
        keycode = 8'h2C; tick(); keycode = 8'h00;
        wait_x(200, 100, "s5_reach");
        chk("s5_reach_y", BallY, 100);
        Brick_Hit = 1; Brick_Hit_Side = 0; tick();
        pos("brick_top", 202, 102);
        Brick_Hit_Side = 1; tick();
        pos("brick_side", 200, 104);
        Brick_Hit = 0; tick();
        pos("brick_after", 198, 106);
        repeat (60) tick();

        // Three losses to OVER, restart.
        do_reset();
        Bar_Sizex = 20;
        lose_life(2);
        count_lost();
        lose_life(1);
        count_lost();
        lose_life(0);
        keycode = 8'h1A;
        repeat (3) tick();
        chk("over_hold", Game_Over, 1);
        pos("over_frozen", 126, 475);
        chk("over_lives", Lives, 0);
        keycode = 8'h2C; tick(); keycode = 8'h00;
        chk("restart_lives", Lives, 3);
        chk("restart_bar_reset", Bar_Reset, 1);
        chk("restart_game_over", Game_Over, 0);
        tick();
        chk("restart_pulse_end", Bar_Reset, 0);
        pos("restart_serve", 600, 453);

        // Asynchronous reset mid-PLAY and mid-LOST.
        do_reset();
        BarX = 100; BarY = 461; tick();
        keycode = 8'h2C; tick(); keycode = 8'h00;
        repeat (5) tick();
        Reset_n = 1'b0; #1;
        pos("rst_play", 320, 452);
        chk("rst_play_launched", Ball_Launched, 0);
        Reset_n = 1'b1;
        tick();
        lose_life(2);
        repeat (10) tick();
        Reset_n = 1'b0; #1;
        pos("rst_lost", 320, 452);
        chk("rst_lost_bar_reset", Bar_Reset, 0);
        chk("rst_lost_lives", Lives, 3);
        Reset_n = 1'b1;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
